// File: rtl/prog_loader.sv
// Program loader: assembles host nibbles into bytes, writes them to program memory and holds the
// CPU in reset until the load completes. Optional checksum stage: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned N          = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned PROG_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              nib_valid,
  input  logic [N-1:0]      nib_data,
  output logic              nib_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2*N-1:0]    wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StHi, StLo, StWrite, StChkHi, StChkLo, StDone, StErr
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StHi, StLo, StWrite, StDone, StErr
  } state_e;
`endif

  localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(PROG_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic              busy_d, done_d, err_d, hold_d;
  logic              xfer, last_byte, len_bad;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [2*N-1:0]    sum_q, sum_d;
`endif

  assign len_bad   = (length == '0) || (length > DepthLen);
  assign last_byte = ({1'b0, addr_q} == (len_q - 1'b1));
  assign xfer      = nib_valid && nib_ready;
  assign wr_addr   = addr_q;
  assign wr_data   = {hi_q, lo_q};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    nib_ready = 1'b0;
    wr_en     = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    // Handshake and strobe depend on state only, never on inputs.
    unique case (state_q)
      StHi, StLo: nib_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      StChkHi, StChkLo: nib_ready = 1'b1;
`endif
      StWrite: wr_en = 1'b1;
      default: ;
    endcase

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          if (len_bad) begin
            state_d = StErr;
          end else begin
            len_d   = length;
            addr_d  = '0;
            state_d = StHi;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end
      end
      StHi: begin
        if (xfer) begin
          hi_d    = nib_data;
          state_d = StLo;
        end
      end
      StLo: begin
        if (xfer) begin
          lo_d    = nib_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d = sum_q + {hi_q, lo_q};
`endif
        if (last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = StChkHi;
`else
          state_d = StDone;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StHi;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StChkHi: begin
        if (xfer) begin
          hi_d    = nib_data;
          state_d = StChkLo;
        end
      end
      StChkLo: begin
        if (xfer) begin
          state_d = ({hi_q, nib_data} == sum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    busy_d = (state_d == StHi) || (state_d == StLo) || (state_d == StWrite);
`ifdef PROG_LOADER_CHECKSUM_EN
    busy_d = busy_d || (state_d == StChkHi) || (state_d == StChkLo);
`endif
    done_d = (state_d == StDone);
    err_d  = (state_d == StErr);
    hold_d = (state_d != StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      addr_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      cpu_hold <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as bytes are sent and checked
// against the write port; status outputs are checked at each phase boundary.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset, start, nib_valid;
  logic [12:0] length;
  logic [3:0]  nib_data;
  logic        nib_ready, wr_en, cpu_hold, busy, done, err;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          wr_count = 0;
  logic [11:0] exp_addr;
  logic [7:0]  exp_sum;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  chk_bias = 8'h00;
`endif

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .nib_valid (nib_valid),
    .nib_data  (nib_data),
    .nib_ready (nib_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && wr_en !== 1'b0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wr", 32'(wr_en), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        wr_count++;
      end
    end
  end

  // All driver tasks are entered and left just after a falling edge.
  task automatic do_start(input logic [12:0] len);
    start  = 1'b1;
    length = len;
    @(negedge clk);
    start    = 1'b0;
    exp_addr = '0;
    exp_sum  = '0;
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_t e;
    e.addr = exp_addr;
    e.data = b;
    sb_q.push_back(e);
    exp_addr = exp_addr + 1'b1;
    exp_sum  = exp_sum + b;
  endtask

  task automatic send_nib(input logic [3:0] d, input bit is_low);
    nib_valid = 1'b1;
    nib_data  = d;
    for (int i = 0; i < 50 && nib_ready !== 1'b1; i++) @(negedge clk);
    if (nib_ready !== 1'b1) begin
      check("nib_ready_timeout", 32'(nib_ready), 32'd1);
    end else begin
      @(negedge clk);
      if (is_low) check("wr_latency", 32'(wr_en), 32'd1);
    end
    nib_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    push_exp(b);
    send_nib(b[7:4], 1'b0);
    send_nib(b[3:0], 1'b1);
  endtask

  // Leaves the bench on the first cycle the loader should report completion.
  task automatic finish_load();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = exp_sum + chk_bias;
    send_nib(c[7:4], 1'b0);
    send_nib(c[3:0], 1'b0);
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    length    = '0;
    nib_valid = 1'b0;
    nib_data  = '0;
    exp_addr  = '0;
    exp_sum   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_nib_ready", 32'(nib_ready), 32'd0);

    // Three-byte back-to-back load.
    do_start(13'd3);
    check("load_busy", 32'(busy), 32'd1);
    check("load_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'hA5);
    send_byte(8'h0F);
    send_byte(8'h12);
    finish_load();
    check("l3_done", 32'(done), 32'd1);
    check("l3_hold", 32'(cpu_hold), 32'd0);
    check("l3_busy", 32'(busy), 32'd0);

    // Restart from DONE with gaps in nib_valid and garbage data during gaps.
    do_start(13'd2);
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_hold", 32'(cpu_hold), 32'd1);
    push_exp(8'h3C);
    send_nib(4'h3, 1'b0);
    nib_data = 4'hF;
    @(negedge clk);
    check("gap_no_accept", 32'(nib_ready), 32'd1);
    send_nib(4'hC, 1'b1);
    push_exp(8'h7E);
    send_nib(4'h7, 1'b0);
    nib_data = 4'h0;
    @(negedge clk);
    send_nib(4'hE, 1'b1);
    finish_load();
    check("gap_done", 32'(done), 32'd1);

    // Illegal lengths, then a legal one from ERR.
    do_start(13'd0);
    check("len0_err", 32'(err), 32'd1);
    check("len0_hold", 32'(cpu_hold), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    do_start(13'd4097);
    check("len4097_err", 32'(err), 32'd1);
    do_start(13'd1);
    check("err_exit", 32'(err), 32'd0);
    check("err_exit_busy", 32'(busy), 32'd1);
    send_byte(8'h5A);
    finish_load();
    check("len1_done", 32'(done), 32'd1);

    // Reset while waiting for the low nibble.
    do_start(13'd2);
    send_nib(4'h6, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(nib_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    do_start(13'd1);
    send_byte(8'h99);
    finish_load();
    check("post_rst_done", 32'(done), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_start(13'd2);
    send_byte(8'h10);
    send_byte(8'h20);
    finish_load();
    check("chk_ok_done", 32'(done), 32'd1);
    check("chk_ok_err", 32'(err), 32'd0);
    chk_bias = 8'h01;
    do_start(13'd2);
    send_byte(8'h10);
    send_byte(8'h20);
    finish_load();
    check("chk_bad_err", 32'(err), 32'd1);
    check("chk_bad_hold", 32'(cpu_hold), 32'd1);
    check("chk_bad_done", 32'(done), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("write_count", 32'(wr_count), 32'd11);
`else
    check("write_count", 32'(wr_count), 32'd7);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
